// File: rtl/ulbf_coeffs_pkg.sv
// Shared constants for the ULBF coefficient port-B reader: FSM encoding,
// CSR status layout and default bus widths.
package ulbf_coeffs_pkg;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 64;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam int unsigned CsrBusyBit = 31;
    localparam int unsigned CsrIgnBit  = 30;
    localparam int unsigned CsrCountW  = 16;

endpackage

// File: rtl/ulbf_coeffs_reader_if.sv
// AXI4-Stream beat interface from the coefficient reader toward the AIE PLIO.
interface ulbf_coeffs_reader_if
    import ulbf_coeffs_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ulbf_coeffs_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; count feeds the read-credit check.
module ulbf_coeffs_rd_fifo
    import ulbf_coeffs_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DefDataW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (PtrW + 1)'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[PtrW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ulbf_coeffs_reader.sv
// Port-B read engine: streams a contiguous block of 64-bit coefficient words
// from BRAM as AXI4-Stream beats, with credit-limited reads into an FWFT FIFO.
module ulbf_coeffs_reader
    import ulbf_coeffs_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [15:0]          num_words,
    output logic                 enb,
    output logic [ADDR_W-1:0]    addrb,
    input  logic [DATA_W-1:0]    doutb,
    ulbf_coeffs_reader_if.master m_axis,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          csr_rddata
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       num_words_q;
    logic [15:0]       rd_cnt_q;
    logic [15:0]       words_sent_q;
    logic [RD_LAT-1:0] vld_q;
    logic              start_ignored_q;
    logic              done_q;

    logic              accept;
    logic              issue;
    logic              fire;
    logic              last_beat;
    logic [CntW-1:0]   fifo_count;
    logic [CntW-1:0]   inflight;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;

    // done_q blocks acceptance so a start coinciding with done is ignored.
    assign accept    = start && (state_q == StIdle) && !done_q;
    assign inflight  = CntW'($countones(vld_q));
    assign issue     = (state_q == StRun) &&
                       (({1'b0, fifo_count} + {1'b0, inflight}) < (CntW + 1)'(FIFO_DEPTH));
    assign fire      = m_axis.tvalid && m_axis.tready;
    assign last_beat = (words_sent_q == num_words_q - 16'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && (num_words != 16'd0)) state_d = StRun;
            StRun:   if (issue && (rd_cnt_q == num_words_q - 16'd1)) state_d = StDrain;
            StDrain: if (fire && last_beat && (inflight == '0)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            num_words_q     <= '0;
            rd_cnt_q        <= '0;
            words_sent_q    <= '0;
            vld_q           <= '0;
            start_ignored_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= (vld_q << 1) | RD_LAT'(issue);
            done_q  <= (accept && (num_words == 16'd0)) ||
                       ((state_q == StDrain) && (state_d == StIdle));
            if (accept) begin
                addr_q          <= base_addr;
                num_words_q     <= num_words;
                rd_cnt_q        <= '0;
                words_sent_q    <= '0;
                start_ignored_q <= 1'b0;
            end else begin
                if (start) start_ignored_q <= 1'b1;
                if (issue) begin
                    addr_q   <= addr_q + ADDR_W'(1);
                    rd_cnt_q <= rd_cnt_q + 16'd1;
                end
                if (fire) words_sent_q <= words_sent_q + 16'd1;
            end
        end
    end

    ulbf_coeffs_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_q[RD_LAT-1]),
        .wr_data (doutb),
        .rd_en   (fire),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign enb           = issue;
    assign addrb         = addr_q;
    assign m_axis.tvalid = !fifo_empty;
    // Gate data so tdata reads zero whenever no beat is offered.
    assign m_axis.tdata  = m_axis.tvalid ? fifo_data : '0;
    assign m_axis.tlast  = m_axis.tvalid && last_beat;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;

    always_comb begin
        csr_rddata                   = '0;
        csr_rddata[CsrBusyBit]       = busy;
        csr_rddata[CsrIgnBit]        = start_ignored_q;
        csr_rddata[CsrCountW-1:0]    = words_sent_q;
    end

endmodule

// File: tb/tb_ulbf_coeffs_reader.sv
// Randomized bench for ulbf_coeffs_reader: a BRAM model feeds the DUT and each
// block's beats are checked against addresses computed from base and index.
module tb_ulbf_coeffs_reader;
    import ulbf_coeffs_pkg::*;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       base_addr = '0;
    logic [15:0]       num_words = '0;
    logic              enb;
    logic [15:0]       addrb;
    logic [63:0]       doutb;
    logic              busy;
    logic              done;
    logic [31:0]       csr_rddata;
    logic [63:0]       bram_hi = '0;
    logic [63:0]       p1 = '0;
    logic [63:0]       p2 = '0;
    int                total = 0;
    int                bad = 0;

    ulbf_coeffs_reader_if #(.DATA_W(DATA_W)) axis ();

    ulbf_coeffs_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb),
        .m_axis     (axis.master),
        .busy       (busy),
        .done       (done),
        .csr_rddata (csr_rddata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] bram_word(input logic [15:0] a);
        return bram_hi | {48'b0, a};
    endfunction

    // Two-stage BRAM read pipeline (RD_LAT = 2).
    always @(posedge clk) begin
        if (enb) p1 <= bram_word(addrb);
        p2 <= p1;
    end
    assign doutb = p2;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one block starting in cycle 0; inj>0 pulses an extra start in that cycle.
    task automatic run_block(input logic [15:0] base, input int n, input int mode, input int inj);
        int        k = 0;
        int        last_hs = 0;
        int        first_v = -1;
        int        budget = 20 + 8 * n;
        bit        seen_done = 0;
        bit        prev_stall = 0;
        logic [63:0] prev_data = '0;
        logic      prev_last = 0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        num_words = 16'(n);
        for (int cyc = 1; cyc <= budget && !seen_done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == inj) begin
                start = 1'b1;
                base_addr = 16'($urandom);
                num_words = 16'($urandom_range(1, 50));
            end else begin
                start = 1'b0;
                base_addr = base;
                num_words = 16'(n);
            end
            case (mode)
                0: axis.tready = 1'b1;
                1: axis.tready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (cyc == 1) check_val("busy_c1", 64'(busy), 64'(n > 0));
            if (cyc == 1 && n > 0) check_val("enb_addr_c1", {47'b0, enb, addrb}, {47'b0, 1'b1, base});
            if (prev_stall) begin
                check_val("hold_valid", 64'(axis.tvalid), 64'd1);
                check_val("hold_data", axis.tdata, prev_data);
                check_val("hold_last", 64'(axis.tlast), 64'(prev_last));
            end
            if (axis.tvalid && first_v < 0) begin
                first_v = cyc;
                check_val("first_valid_cyc", 64'(cyc), 64'(2 + RD_LAT));
            end
            if (axis.tvalid && axis.tready) begin
                check_val("beat_data", axis.tdata, bram_word(base + 16'(k)));
                check_val("beat_last", 64'(axis.tlast), 64'(k == n - 1));
                k++;
                last_hs = cyc;
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data = axis.tdata;
            prev_last = axis.tlast;
            if (done) begin
                seen_done = 1;
                check_val("done_cyc", 64'(cyc), 64'((n == 0) ? 1 : last_hs + 1));
                check_val("beat_count", 64'(k), 64'(n));
                check_val("busy_at_done", 64'(busy), 64'd0);
                check_val("words_sent", 64'(csr_rddata[15:0]), 64'(n));
            end
        end
        if (!seen_done) check_val("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = base;
        num_words = 16'(n);
        axis.tready = 1'b1;
        @(negedge clk);
        check_val("start_ignored", 64'(csr_rddata[CsrIgnBit]), 64'(inj > 0));
        check_val("idle_after", {62'b0, busy, axis.tvalid}, 64'd0);
    endtask

    initial begin
        int stale;
        axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_outputs", {enb, addrb, axis.tvalid, axis.tlast, busy, done, csr_rddata},
                  '0);
        check_val("rst_tdata", axis.tdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        bram_hi = '0;
        run_block(16'h0010, 8, 0, 0);
        run_block(16'h0010, 8, 1, 0);
        bram_hi = 64'hDEAD_BEEF_1234_0000;
        run_block(16'hFFFE, 4, 2, 0);
        run_block(16'h0000, 0, 0, 0);
        run_block(16'h0010, 8, 0, 3);
        run_block(16'h0020, 3, 0, 0);
        run_block(16'h0100, 5, 0, 5 + 2 + RD_LAT);

        // Reset in cycle 6 of a 16-word block.
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 16'h0200;
        num_words = 16'd16;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 6) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_outputs", {enb, addrb, axis.tvalid, axis.tlast, busy, done, csr_rddata},
                  '0);
        check_val("midrst_tdata", axis.tdata, 64'd0);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (axis.tvalid || enb || busy) stale++;
        end
        check_val("no_stale_beat", 64'(stale), 64'd0);
        run_block(16'h0300, 2, 2, 0);

        for (int i = 0; i < 12; i++) begin
            int n;
            int inj;
            logic [15:0] b;
            bram_hi = {$urandom, 16'($urandom), 16'h0000};
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            b = ($urandom_range(0, 2) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                            : 16'($urandom);
            inj = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n + 2)) : 0;
            run_block(b, n, int'($urandom_range(0, 2)), inj);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
